// File: rtl/fft_input_loader.sv
// rtl/fft_input_loader.sv - serial-to-parallel 8-sample frame loader for the FFT pipeline
// Define FFT_LOADER_BITREV_EN to store sample n in slot bitrev(n); otherwise natural order.
module fft_input_loader #(
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2**N-1:0] s_r,
  input  logic [2**N-1:0] s_i,
  input  logic            s_valid,
  input  logic            s_last,
  output logic            s_ready,
  output logic [2**N-1:0] out_0_r,
  output logic [2**N-1:0] out_0_i,
  output logic [2**N-1:0] out_1_r,
  output logic [2**N-1:0] out_1_i,
  output logic [2**N-1:0] out_2_r,
  output logic [2**N-1:0] out_2_i,
  output logic [2**N-1:0] out_3_r,
  output logic [2**N-1:0] out_3_i,
  output logic [2**N-1:0] out_4_r,
  output logic [2**N-1:0] out_4_i,
  output logic [2**N-1:0] out_5_r,
  output logic [2**N-1:0] out_5_i,
  output logic [2**N-1:0] out_6_r,
  output logic [2**N-1:0] out_6_i,
  output logic [2**N-1:0] out_7_r,
  output logic [2**N-1:0] out_7_i,
  output logic            frame_valid,
  input  logic            frame_ack,
  output logic            frame_err
);

  localparam int W = 2**N;

  typedef enum logic [1:0] {INIT, FILL, HOLD} state_t;

  state_t         state;
  logic [2:0]     cnt;
  logic [W-1:0]   slot_r [8];
  logic [W-1:0]   slot_i [8];

  function automatic logic [2:0] map_slot(input logic [2:0] c);
`ifdef FFT_LOADER_BITREV_EN
    return {c[0], c[1], c[2]};
`else
    return c;
`endif
  endfunction

  // s_ready is high exactly while in FILL, so it doubles as the handshake qualifier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= INIT;
      cnt         <= 3'd0;
      s_ready     <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        slot_r[k] <= '0;
        slot_i[k] <= '0;
      end
    end else begin
      frame_err <= 1'b0;
      case (state)
        INIT: begin
          state   <= FILL;
          cnt     <= 3'd0;
          s_ready <= 1'b1;
        end
        FILL: begin
          if (s_valid && s_ready) begin
            slot_r[map_slot(cnt)] <= s_r;
            slot_i[map_slot(cnt)] <= s_i;
            if (cnt == 3'd7 && s_last) begin
              state       <= HOLD;
              cnt         <= 3'd0;
              s_ready     <= 1'b0;
              frame_valid <= 1'b1;
            end else if (cnt == 3'd7 || s_last) begin
              // misaligned frame: restart from slot 0, leftovers get overwritten
              cnt       <= 3'd0;
              frame_err <= 1'b1;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        HOLD: begin
          if (frame_ack) begin
            state       <= FILL;
            cnt         <= 3'd0;
            s_ready     <= 1'b1;
            frame_valid <= 1'b0;
          end
        end
        default: begin
          state       <= INIT;
          cnt         <= 3'd0;
          s_ready     <= 1'b0;
          frame_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_0_r = slot_r[0];
  assign out_0_i = slot_i[0];
  assign out_1_r = slot_r[1];
  assign out_1_i = slot_i[1];
  assign out_2_r = slot_r[2];
  assign out_2_i = slot_i[2];
  assign out_3_r = slot_r[3];
  assign out_3_i = slot_i[3];
  assign out_4_r = slot_r[4];
  assign out_4_i = slot_i[4];
  assign out_5_r = slot_r[5];
  assign out_5_i = slot_i[5];
  assign out_6_r = slot_r[6];
  assign out_6_i = slot_i[6];
  assign out_7_r = slot_r[7];
  assign out_7_i = slot_i[7];

endmodule
